peripheral_mpi_arbiter: RTL and testbench

- Shares one MPI peripheral register port (14-bit address, 16-bit data, per_en/per_we protocol) among NUM_REQ requesters, e.g. CPU, DMA and debug.
- Round-robin arbitration, with an optional bounded lock for multi-register sequences.
- Sequences each access as an address phase followed by a data phase, and returns the read data to the owning requester.
- Sits between the requesters' bus ports and the MPI peripheral's per_* interface.

---
 rtl/peripheral_mpi_arbiter_pkg.sv | 20 ++
 rtl/peripheral_mpi_rr_picker.sv | 49 ++++
 rtl/peripheral_mpi_arbiter.sv | 143 ++++++++++++++
 tb/tb_peripheral_mpi_arbiter.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_mpi_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | peripheral_mpi_arbiter_pkg : shared types/constants for the MPI arbiter  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package peripheral_mpi_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int MPI_AW = 14;
    localparam int MPI_DW = 16;

    localparam logic [1:0] WE_READ = 2'b00;

endpackage
`default_nettype wire

// File: rtl/peripheral_mpi_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | peripheral_mpi_rr_picker : combinational cyclic first-set finder         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module peripheral_mpi_rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] winner
);

    localparam int            IW1 = IW + 1;
    localparam logic [IW:0]   N_W = IW1'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // Doubling the vector turns the cyclic search into a plain shifted window.
    assign dbl = {valid, valid};

    always_comb begin
        rot   = '0;
        found = 1'b0;
        off   = '0;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = dbl[{1'b0, start} + IW1'(i)];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = IW'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        winner = sum[IW-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/peripheral_mpi_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | peripheral_mpi_arbiter : round-robin sharing of one MPI peripheral port  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module peripheral_mpi_arbiter
    import peripheral_mpi_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int AW       = MPI_AW,
    parameter int DW       = MPI_DW,
    parameter int LOCK_MAX = 8
) (
    input  logic                       mclk,
    input  logic                       puc_rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [NUM_REQ*AW-1:0]      req_addr,
    input  logic [NUM_REQ*DW-1:0]      req_din,
    input  logic [NUM_REQ*2-1:0]       req_we,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DW-1:0]              rsp_dout,
    output logic [AW-1:0]              per_addr,
    output logic [DW-1:0]              per_din,
    output logic                       per_en,
    output logic [1:0]                 per_we,
    input  logic [DW-1:0]              per_dout,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner
);

    localparam int              IW       = $clog2(NUM_REQ);
    localparam int              HW       = $clog2(LOCK_MAX + 1);
    localparam logic [HW-1:0]   LOCK_LIM = HW'(LOCK_MAX - 1);
    localparam logic [IW-1:0]   LAST     = IW'(NUM_REQ - 1);

    state_e         state_q,    state_d;
    logic [IW-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [IW-1:0]  owner_q,    owner_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [AW-1:0]  addr_q,     addr_d;
    logic [DW-1:0]  din_q,      din_d;
    logic [1:0]     we_q,       we_d;

    logic           pick_found;
    logic [IW-1:0]  pick_winner;
    logic           arb;
    logic           locked;
    logic           grant;
    logic [IW-1:0]  gnt_idx;

    peripheral_mpi_rr_picker #(
        .N      (NUM_REQ)
    ) u_picker (
        .valid  (req_valid),
        .start  (rr_ptr_q),
        .found  (pick_found),
        .winner (pick_winner)
    );

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            we_q       <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            we_q       <= we_d;
        end
    end

    always_comb begin
        state_d    = IDLE;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        addr_d     = addr_q;
        din_d      = din_q;
        we_d       = we_q;
        req_ready  = '0;
        grant      = 1'b0;
        gnt_idx    = pick_winner;

        // Gating with reset keeps req_ready quiet while the arbiter is held.
        arb    = puc_rst_n && ((state_q == IDLE) || (state_q == RESP));
        locked = (state_q == RESP) && req_lock[owner_q] && req_valid[owner_q]
                 && (hold_cnt_q < LOCK_LIM);

        if (state_q == ACCESS) begin
            state_d = RESP;
        end

        if (arb) begin
            if (locked) begin
                grant      = 1'b1;
                gnt_idx    = owner_q;
                hold_cnt_d = hold_cnt_q + HW'(1);
            end else begin
                hold_cnt_d = '0;
                if (pick_found) begin
                    grant    = 1'b1;
                    gnt_idx  = pick_winner;
                    rr_ptr_d = (pick_winner == LAST) ? '0 : pick_winner + IW'(1);
                end
            end
            if (grant) begin
                req_ready[gnt_idx] = 1'b1;
                owner_d            = gnt_idx;
                addr_d             = req_addr[gnt_idx*AW +: AW];
                din_d              = req_din[gnt_idx*DW +: DW];
                we_d               = req_we[gnt_idx*2 +: 2];
                state_d            = ACCESS;
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    assign per_en   = (state_q == ACCESS);
    assign per_addr = per_en ? addr_q : '0;
    assign per_din  = per_en ? din_q  : '0;
    assign per_we   = per_en ? we_q   : '0;
    assign rsp_dout = ((state_q == RESP) && (we_q == WE_READ)) ? per_dout : '0;
    assign busy     = (state_q != IDLE);
    assign owner    = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_mpi_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_peripheral_mpi_arbiter : scoreboard bench for the MPI arbiter         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_peripheral_mpi_arbiter;

    localparam int N        = 4;
    localparam int AW       = 14;
    localparam int DW       = 16;
    localparam int LOCK_MAX = 8;

    typedef struct {
        int            id;
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [1:0]    we;
        logic [DW-1:0] data;
    } sb_t;

    logic            mclk      = 1'b0;
    logic            puc_rst_n = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_din;
    logic [N*2-1:0]  req_we;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_dout;
    logic [AW-1:0]   per_addr;
    logic [DW-1:0]   per_din;
    logic [DW-1:0]   per_dout = '0;
    logic            per_en;
    logic [1:0]      per_we;
    logic            busy;
    logic [1:0]      owner;

    logic [AW-1:0]   ra [N];
    logic [DW-1:0]   rd [N];
    logic [1:0]      rw [N];

    logic [DW-1:0]   pmem [64];
    logic [DW-1:0]   smem [64];

    sb_t acc_q [$];
    sb_t rsp_q [$];
    int  grant_q [$];
    int  gcyc_q [$];

    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign req_addr[gi*AW +: AW] = ra[gi];
            assign req_din[gi*DW +: DW]  = rd[gi];
            assign req_we[gi*2 +: 2]     = rw[gi];
        end
    endgenerate

    peripheral_mpi_arbiter #(
        .NUM_REQ   (N),
        .AW        (AW),
        .DW        (DW),
        .LOCK_MAX  (LOCK_MAX)
    ) dut (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_din   (req_din),
        .req_we    (req_we),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_dout  (rsp_dout),
        .per_addr  (per_addr),
        .per_din   (per_din),
        .per_en    (per_en),
        .per_we    (per_we),
        .per_dout  (per_dout),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 mclk = ~mclk;

    // Peripheral model: read data appears the cycle after per_en, junk otherwise.
    always @(posedge mclk) begin
        cyc <= cyc + 1;
        if (per_en) begin
            if (per_we == 2'b00) begin
                per_dout <= pmem[per_addr[5:0]];
            end else begin
                if (per_we[0]) pmem[per_addr[5:0]][7:0]  <= per_din[7:0];
                if (per_we[1]) pmem[per_addr[5:0]][15:8] <= per_din[15:8];
                per_dout <= 16'hDEAD;
            end
        end else begin
            per_dout <= 16'hBEEF;
        end
    end

    always @(negedge mclk) begin
        sb_t          e;
        logic [N-1:0] oh;
        if (!puc_rst_n) begin
            acc_q.delete();
            rsp_q.delete();
        end else begin
            n_tests++;
            if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != '0)) begin
                n_fail++;
                $display("FAIL ready_legal: req_ready=%b req_valid=%b", req_ready, req_valid);
            end
            if (per_en) begin
                n_tests++;
                if (acc_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL per_en_unexpected: per_en=1 with no accepted request at cycle %0d", cyc);
                end else begin
                    e = acc_q.pop_front();
                    if (per_addr !== e.addr || per_din !== e.din || per_we !== e.we || cyc != e.cyc + 1) begin
                        n_fail++;
                        $display("FAIL per_access: got addr=%h din=%h we=%b cyc=%0d, want addr=%h din=%h we=%b cyc=%0d",
                                 per_addr, per_din, per_we, cyc, e.addr, e.din, e.we, e.cyc + 1);
                    end
                end
            end else begin
                n_tests++;
                if ({per_addr, per_din, per_we} !== '0) begin
                    n_fail++;
                    $display("FAIL per_idle_zero: addr=%h din=%h we=%b want all 0", per_addr, per_din, per_we);
                end
            end
            if (rsp_valid != '0) begin
                n_tests++;
                if (rsp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding", rsp_valid);
                end else begin
                    e  = rsp_q.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    if (rsp_valid !== oh || rsp_dout !== e.data || cyc != e.cyc + 2) begin
                        n_fail++;
                        $display("FAIL rsp: got valid=%b dout=%h cyc=%0d, want valid=%b dout=%h cyc=%0d",
                                 rsp_valid, rsp_dout, cyc, oh, e.data, e.cyc + 2);
                    end
                end
            end else begin
                n_tests++;
                if (rsp_dout !== '0) begin
                    n_fail++;
                    $display("FAIL rsp_idle_zero: rsp_dout=%h want 0", rsp_dout);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    e.id   = i;
                    e.cyc  = cyc;
                    e.addr = ra[i];
                    e.din  = rd[i];
                    e.we   = rw[i];
                    if (rw[i] == 2'b00) begin
                        e.data = smem[ra[i][5:0]];
                    end else begin
                        e.data = '0;
                        if (rw[i][0]) smem[ra[i][5:0]][7:0]  = rd[i][7:0];
                        if (rw[i][1]) smem[ra[i][5:0]][15:8] = rd[i][15:8];
                    end
                    acc_q.push_back(e);
                    rsp_q.push_back(e);
                    grant_q.push_back(i);
                    gcyc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic at_neg();
        @(negedge mclk);
        #1;
    endtask

    task automatic at_pos();
        @(posedge mclk);
        #1;
    endtask

    task automatic wait_grants(input int n, input int budget);
        for (int k = 0; k < budget && grant_q.size() < n; k++) at_neg();
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && (busy || rsp_q.size() != 0); k++) at_neg();
    endtask

    // Presents one request and drops it after acceptance; ends just after T+1 starts.
    task automatic issue(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [1:0] w, output logic [N-1:0] rdy_t);
        at_pos();
        ra[id] = a;
        rd[id] = d;
        rw[id] = w;
        req_valid = '0;
        req_valid[id] = 1'b1;
        at_neg();
        rdy_t = req_ready;
        at_pos();
        req_valid = '0;
    endtask

    task automatic test_reset();
        req_valid = '1;
        #1;
        n_tests++;
        if (req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_ready: req_ready=%b want 0", req_ready);
        end
        n_tests++;
        if ({rsp_valid, per_en, per_addr, per_din, per_we, rsp_dout, busy, owner} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rsp_valid=%b per_en=%b busy=%b owner=%0d want all 0",
                     rsp_valid, per_en, busy, owner);
        end
        req_valid = '0;
        at_pos();
        puc_rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        logic [N-1:0] r;
        issue(0, 14'h0040, 16'h0000, 2'b00, r);
        n_tests++;
        if (r !== 4'b0001) begin
            n_fail++;
            $display("FAIL read_ready: req_ready=%b want 0001", r);
        end
        at_neg();
        n_tests++;
        if (per_en !== 1'b1 || per_addr !== 14'h0040 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL read_access: per_en=%b per_addr=%h busy=%b want 1 0040 1", per_en, per_addr, busy);
        end
        at_neg();
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_dout !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL read_rsp: rsp_valid=%b rsp_dout=%h want 0001 a5c3", rsp_valid, rsp_dout);
        end
        at_neg();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_write();
        logic [N-1:0] r;
        issue(2, 14'h0105, 16'h1234, 2'b11, r);
        n_tests++;
        if (r !== 4'b0100) begin
            n_fail++;
            $display("FAIL write_ready: req_ready=%b want 0100", r);
        end
        at_neg();
        n_tests++;
        if (per_we !== 2'b11 || per_din !== 16'h1234 || per_addr !== 14'h0105) begin
            n_fail++;
            $display("FAIL write_access: per_we=%b per_din=%h per_addr=%h want 11 1234 0105", per_we, per_din, per_addr);
        end
        at_neg();
        n_tests++;
        if (rsp_valid !== 4'b0100 || rsp_dout !== 16'h0000) begin
            n_fail++;
            $display("FAIL write_rsp: rsp_valid=%b rsp_dout=%h want 0100 0000", rsp_valid, rsp_dout);
        end
        issue(3, 14'h0005, 16'h0000, 2'b00, r);
        at_neg();
        at_neg();
        n_tests++;
        if (rsp_valid !== 4'b1000 || rsp_dout !== 16'h1234) begin
            n_fail++;
            $display("FAIL write_readback: rsp_valid=%b rsp_dout=%h want 1000 1234", rsp_valid, rsp_dout);
        end
        issue(1, 14'h0005, 16'hAB00, 2'b10, r);
        at_neg();
        issue(3, 14'h0005, 16'h0000, 2'b00, r);
        at_neg();
        at_neg();
        n_tests++;
        if (rsp_dout !== 16'hAB34) begin
            n_fail++;
            $display("FAIL byte_write_readback: rsp_dout=%h want ab34", rsp_dout);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int exp_order[6];
        exp_order = '{0, 1, 2, 3, 0, 1};
        at_pos();
        for (int i = 0; i < N; i++) begin
            ra[i] = AW'(14'h0010 + i);
            rw[i] = 2'b00;
        end
        grant_q.delete();
        gcyc_q.delete();
        req_valid = '1;
        wait_grants(6, 40);
        at_pos();
        req_valid = '0;
        n_tests++;
        if (grant_q.size() < 6) begin
            n_fail++;
            $display("FAIL rr_timeout: %0d grants seen want 6", grant_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_tests++;
                if (grant_q[k] != exp_order[k]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: granted %0d want %0d", k, grant_q[k], exp_order[k]);
                end
            end
            for (int k = 1; k < 6; k++) begin
                n_tests++;
                if (gcyc_q[k] - gcyc_q[k-1] != 2) begin
                    n_fail++;
                    $display("FAIL rr_spacing[%0d]: gap %0d cycles want 2", k, gcyc_q[k] - gcyc_q[k-1]);
                end
            end
        end
        drain();
    endtask

    task automatic test_lock();
        at_pos();
        for (int i = 0; i < N; i++) begin
            ra[i] = AW'(14'h0020 + i);
            rw[i] = 2'b00;
        end
        grant_q.delete();
        req_lock  = 4'b0010;
        req_valid = 4'b0010;
        wait_grants(1, 10);
        at_pos();
        req_valid = 4'b1111;
        wait_grants(9, 60);
        at_pos();
        req_valid = '0;
        req_lock  = '0;
        n_tests++;
        if (grant_q.size() < 9) begin
            n_fail++;
            $display("FAIL lock_timeout: %0d grants seen want 9", grant_q.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                n_tests++;
                if (grant_q[k] != ((k < LOCK_MAX) ? 1 : 2)) begin
                    n_fail++;
                    $display("FAIL lock_order[%0d]: granted %0d want %0d", k, grant_q[k], (k < LOCK_MAX) ? 1 : 2);
                end
            end
        end
        drain();
    endtask

    task automatic test_sparse_wrap();
        at_pos();
        grant_q.delete();
        req_valid = 4'b0010;
        wait_grants(1, 10);
        at_pos();
        req_valid = '0;
        n_tests++;
        if (grant_q.size() < 1 || grant_q[0] != 1) begin
            n_fail++;
            $display("FAIL sparse_grant: grants=%0d first=%0d want 1", grant_q.size(),
                     (grant_q.size() > 0) ? grant_q[0] : -1);
        end
        drain();
        at_pos();
        grant_q.delete();
        req_valid = 4'b1001;
        wait_grants(2, 20);
        at_pos();
        req_valid = '0;
        n_tests++;
        if (grant_q.size() < 2 || grant_q[0] != 3 || grant_q[1] != 0) begin
            n_fail++;
            $display("FAIL wrap_order: grants=%0d first=%0d second=%0d want 3 then 0", grant_q.size(),
                     (grant_q.size() > 0) ? grant_q[0] : -1, (grant_q.size() > 1) ? grant_q[1] : -1);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        at_pos();
        grant_q.delete();
        req_valid = '1;
        wait_grants(1, 10);
        n_tests++;
        if (grant_q.size() < 1 || grant_q[0] != 1) begin
            n_fail++;
            $display("FAIL pre_reset_grant: first=%0d want 1", (grant_q.size() > 0) ? grant_q[0] : -1);
        end
        at_pos();
        n_tests++;
        if (per_en !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_access: per_en=%b want 1", per_en);
        end
        puc_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({per_en, per_addr, per_din, per_we, rsp_valid, rsp_dout, busy, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: per_en=%b rsp_valid=%b busy=%b req_ready=%b want all 0",
                     per_en, rsp_valid, busy, req_ready);
        end
        at_neg();
        n_tests++;
        if (rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_rsp: rsp_valid=%b want 0", rsp_valid);
        end
        at_pos();
        grant_q.delete();
        puc_rst_n = 1'b1;
        wait_grants(1, 10);
        at_pos();
        req_valid = '0;
        n_tests++;
        if (grant_q.size() < 1 || grant_q[0] != 0) begin
            n_fail++;
            $display("FAIL post_reset_grant: first=%0d want 0", (grant_q.size() > 0) ? grant_q[0] : -1);
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            pmem[i] = 16'hA5C3 + 16'(i) * 16'h0111;
            smem[i] = 16'hA5C3 + 16'(i) * 16'h0111;
        end
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rd[i] = '0;
            rw[i] = '0;
        end
        req_valid = '0;
        req_lock  = '0;
        #2;
        puc_rst_n = 1'b0;
        repeat (2) @(posedge mclk);
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_lock();
        test_sparse_wrap();
        test_reset_mid();
        n_tests++;
        if (rsp_q.size() != 0 || acc_q.size() != 0) begin
            n_fail++;
            $display("FAIL outstanding: %0d responses and %0d accesses still pending, want 0", rsp_q.size(), acc_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
